// File: rtl/pin_arbiter.sv
// Shared pin bank: round-robin write arbitration for NREQ requesters over
// 32 output/enable bits, plus a synchronised, per-requester rotated read path.
module pin_arbiter #(
  parameter int NREQ        = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ-1:0]      wdir_i,
  input  logic [32*NREQ-1:0]   wdata_i,
  input  logic [5*NREQ-1:0]    wbase_i,
  input  logic [6*NREQ-1:0]    wcount_i,
  output logic [NREQ-1:0]      grant_o,
  input  logic [31:0]          pins_in_i,
  input  logic [5*NREQ-1:0]    in_base_i,
  output logic [32*NREQ-1:0]   rdata_o,
  output logic [31:0]          pins_out_o,
  output logic [31:0]          pins_oe_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} << s;
    return t[63:32];
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] s);
    logic [63:0] t;
    t = {x, x} >> s;
    return t[31:0];
  endfunction

  // Counts above 32 saturate to a full-width field.
  function automatic logic [31:0] low_mask(input logic [5:0] cnt);
    if (cnt >= 6'd32) return '1;
    return (32'd1 << cnt[4:0]) - 32'd1;
  endfunction

  logic [PW-1:0] ptr_q, ptr_d;
  logic [31:0]   pins_out_q, pins_out_d;
  logic [31:0]   pins_oe_q, pins_oe_d;
  logic [31:0]   sync_q [SYNC_STAGES];

  logic          win_valid;
  logic [PW-1:0] win_idx;
  logic [PW-1:0] scan_idx;

  // NOTE: every variable assigned in always_comb gets a default at the top,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_idx  = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!win_valid && req_i[scan_idx]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
      scan_idx = (scan_idx == PW'(NREQ - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  assign grant_o = win_valid ? (NREQ'(1) << win_idx) : '0;

  logic [31:0] sel_data, wr_val, wr_mask;
  logic [4:0]  sel_base;
  logic [5:0]  sel_cnt;
  logic        sel_dir;

  always_comb begin
    sel_data = wdata_i[32*int'(win_idx) +: 32];
    sel_base = wbase_i[5*int'(win_idx) +: 5];
    sel_cnt  = wcount_i[6*int'(win_idx) +: 6];
    sel_dir  = wdir_i[win_idx];
    wr_val   = rotl32(sel_data, sel_base);
    wr_mask  = rotl32(low_mask(sel_cnt), sel_base);
  end

  always_comb begin
    ptr_d      = ptr_q;
    pins_out_d = pins_out_q;
    pins_oe_d  = pins_oe_q;
    if (win_valid) begin
      ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
      if (sel_dir) pins_oe_d  = (pins_oe_q  & ~wr_mask) | (wr_val & wr_mask);
      else         pins_out_d = (pins_out_q & ~wr_mask) | (wr_val & wr_mask);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      pins_out_q <= '0;
      pins_oe_q  <= '0;
    end else begin
      ptr_q      <= ptr_d;
      pins_out_q <= pins_out_d;
      pins_oe_q  <= pins_oe_d;
    end
  end

  // NOTE: the synchroniser array is reset explicitly, element by element, so
  // rdata reads zero during reset instead of stale or unknown levels.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= pins_in_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_read
    assign rdata_o[32*i +: 32] = rotr32(sync_q[SYNC_STAGES-1], in_base_i[5*i +: 5]);
  end

  assign pins_out_o = pins_out_q;
  assign pins_oe_o  = pins_oe_q;

endmodule

// File: tb/tb_pin_arbiter.sv
// Self-checking bench for pin_arbiter: directed scenarios followed by random
// traffic, all compared against a pin-by-pin behavioural model.
module tb_pin_arbiter;

  localparam int N = 4;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req, wdir, grant;
  logic [32*N-1:0] wdata, rdata;
  logic [5*N-1:0]  wbase, in_base;
  logic [6*N-1:0]  wcount;
  logic [31:0]   pins_in, pins_out, pins_oe;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [31:0] m_out, m_oe;
  int          m_ptr;
  logic [31:0] hist [$];

  pin_arbiter #(.NREQ(N), .SYNC_STAGES(S)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .wdir_i     (wdir),
    .wdata_i    (wdata),
    .wbase_i    (wbase),
    .wcount_i   (wcount),
    .grant_o    (grant),
    .pins_in_i  (pins_in),
    .in_base_i  (in_base),
    .rdata_o    (rdata),
    .pins_out_o (pins_out),
    .pins_oe_o  (pins_oe)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_out = '0;
    m_oe  = '0;
    m_ptr = 0;
    hist.delete();
  endtask

  function automatic int model_winner();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  // One rising edge out of reset: apply the winner's field pin by pin.
  task automatic model_apply(int w);
    if (w >= 0) begin
      int cnt, base;
      cnt  = int'(wcount[6*w +: 6]);
      if (cnt > 32) cnt = 32;
      base = int'(wbase[5*w +: 5]);
      for (int j = 0; j < cnt; j++) begin
        int pin;
        pin = (base + j) % 32;
        if (wdir[w]) m_oe[pin]  = wdata[32*w + j];
        else         m_out[pin] = wdata[32*w + j];
      end
      m_ptr = (w + 1) % N;
    end
    hist.push_front(pins_in);
    if (hist.size() > 4) void'(hist.pop_back());
  endtask

  function automatic logic [31:0] model_rdata(int i);
    logic [31:0] sync, r;
    int base;
    sync = (hist.size() >= S) ? hist[S-1] : 32'h0;
    base = int'(in_base[5*i +: 5]);
    for (int k = 0; k < 32; k++) r[k] = sync[(base + k) % 32];
    return r;
  endfunction

  task automatic clear_writes();
    req = '0; wdir = '0; wdata = '0; wbase = '0; wcount = '0;
  endtask

  task automatic set_req(int i, bit dir, logic [31:0] d, int base, int cnt);
    req[i]            = 1'b1;
    wdir[i]           = dir;
    wdata[32*i +: 32] = d;
    wbase[5*i +: 5]   = 5'(base);
    wcount[6*i +: 6]  = 6'(cnt);
  endtask

  // Check grant before the edge, advance one clock, then check all state.
  task automatic step(string tag, output logic [N-1:0] g);
    int w;
    logic [N-1:0] eg;
    #1;
    w  = model_winner();
    eg = (w < 0) ? '0 : N'(1 << w);
    g  = grant;
    check({tag, "_grant"}, 32'(grant), 32'(eg));
    @(posedge clk);
    if (rst_n) model_apply(w);
    #1;
    check({tag, "_out"}, pins_out, m_out);
    check({tag, "_oe"}, pins_oe, m_oe);
    for (int i = 0; i < N; i++) check({tag, "_rdata"}, rdata[32*i +: 32], model_rdata(i));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] g;

    // Reset: outputs cleared, grant still combinational, no write applied.
    rst_n = 1'b0;
    model_reset();
    clear_writes();
    in_base = '0;
    pins_in = 32'hDEAD_BEEF;
    set_req(2, 1'b0, 32'hFFFF_FFFF, 0, 32);
    #2;
    check("rst_grant", 32'(grant), 32'h4);
    check("rst_out", pins_out, 32'h0);
    check("rst_oe", pins_oe, 32'h0);
    check("rst_rdata", rdata[31:0], 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_out", pins_out, 32'h0);
    check("rst_hold_rdata", rdata[63:32], 32'h0);
    rst_n = 1'b1;
    pins_in = 32'h0;
    clear_writes();

    // Direction write of a 4-bit field at pin 4.
    set_req(0, 1'b1, 32'hF, 4, 4);
    step("dir_field", g);
    check("dir_field_g", 32'(g), 32'h1);
    check("dir_field_oe", pins_oe, 32'h0000_00F0);
    clear_writes();

    // Output write wrapping from pin 31 to pin 0.
    set_req(0, 1'b0, 32'hA, 30, 4);
    step("wrap", g);
    check("wrap_out", pins_out, 32'h8000_0002);
    check("wrap_oe", pins_oe, 32'h0000_00F0);
    clear_writes();

    // Round-robin fairness with all requesters held.
    do_reset();
    for (int c = 0; c < 8; c++) begin
      req = '1;
      step("rr", g);
      check("rr_seq", 32'(g), 32'(1 << (c % N)));
    end
    clear_writes();

    // Zero-width write is a no-op; oversize count saturates to 32.
    set_req(2, 1'b0, 32'hFFFF_FFFF, 0, 32);
    step("fill", g);
    check("fill_out", pins_out, 32'hFFFF_FFFF);
    clear_writes();
    set_req(2, 1'b0, 32'h0, 0, 0);
    step("cnt0", g);
    check("cnt0_g", 32'(g), 32'h4);
    check("cnt0_out", pins_out, 32'hFFFF_FFFF);
    clear_writes();
    set_req(2, 1'b0, 32'h0, 0, 40);
    step("cnt40", g);
    check("cnt40_out", pins_out, 32'h0);
    clear_writes();

    // Read latency through the synchroniser with a rotated view.
    do_reset();
    in_base[4:0] = 5'd8;
    step("sync_idle0", g);
    step("sync_idle1", g);
    pins_in = 32'h0000_0100;
    step("sync_e1", g);
    check("sync_e1_r0", rdata[31:0], 32'h0);
    step("sync_e2", g);
    check("sync_e2_r0", rdata[31:0], 32'h1);

    // Reset landing mid-cycle on a granted write discards it and clears ptr.
    set_req(1, 1'b0, 32'h5A5A_0000, 0, 32);
    step("pre_abort", g);
    clear_writes();
    set_req(2, 1'b0, 32'h0000_FFFF, 0, 16);
    #1;
    check("abort_grant", 32'(grant), 32'h4);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("abort_out_async", pins_out, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_writes();
    check("abort_out", pins_out, 32'h0);
    req = '1;
    step("post_abort", g);
    check("post_abort_ptr0", 32'(g), 32'h1);
    clear_writes();

    // Random traffic against the model.
    for (int t = 0; t < 300; t++) begin
      req     = N'($urandom);
      wdir    = N'($urandom);
      wdata   = {$urandom(), $urandom(), $urandom(), $urandom()};
      wbase   = 20'($urandom);
      in_base = 20'($urandom);
      for (int i = 0; i < N; i++) wcount[6*i +: 6] = 6'($urandom_range(0, 40));
      pins_in = $urandom();
      step("rand", g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
